// File: rtl/sr_cmd_sequencer_pkg.sv
// sr_cmd_pkg: shared types for the SR command sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer FSM states
//   op_target(): value Q must settle to for a given opcode
package sr_cmd_pkg;
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_SET = 2'b01,
    OP_RST = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int ERR_CNT_MAX = 255;

  // Expected Q after the command, given Q as seen at acceptance.
  function automatic logic op_target(input op_e op, input logic q);
    unique case (op)
      OP_SET:  return 1'b1;
      OP_RST:  return 1'b0;
      OP_TGL:  return ~q;
      default: return q;
    endcase
  endfunction
endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Command handshake between a requester (master) and the sequencer (slave).
//   cmd_valid : command present
//   cmd_op    : opcode, sampled only on acceptance
//   cmd_ready : sequencer idle and accepting
interface sr_cmd_sequencer_if;
  import sr_cmd_pkg::*;
  logic cmd_valid;
  op_e  cmd_op;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_hold_timer.sv
// Shared cycle counter for DRIVE hold and CHECK timeout.
//   clr   : load zero (wins over en)
//   en    : advance by one
//   limit : runtime cycle limit (>=1)
//   tc    : counter is on the last cycle of the limit (cnt == limit-1)
module sr_hold_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          tc
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == limit - CW'(1));
endmodule

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer feeding an SR flip-flop stage.
//   cmd     : valid/ready command port (slave side)
//   q_fb    : Q fed back from the SR stage
//   S, R    : registered set/reset drives, never both high
//   busy    : sequencer in DRIVE or CHECK
//   done    : one-cycle pulse when Q reached the target
//   err     : one-cycle pulse when CHECK timed out
//   err_cnt : saturating count of timeouts
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int HOLD_CYC = 1,
  parameter int TIMEOUT  = 4,
  parameter int CW       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_cmd_sequencer_if.slave   cmd,
  input  logic                q_fb,
  output logic                S,
  output logic                R,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [7:0]          err_cnt
);
  state_e        state, nxt;
  logic          tgt, tgt_nxt;
  logic          rdy_en;      // holds cmd_ready low for the first cycle out of reset
  logic          accept;
  logic          clr, en, tc;
  logic          done_nxt, err_nxt;
  logic [CW-1:0] limit;

  assign cmd.cmd_ready = rdy_en && (state == IDLE);
  assign accept        = cmd.cmd_ready && cmd.cmd_valid;
  assign busy          = (state != IDLE);
  assign limit         = (state == DRIVE) ? CW'(HOLD_CYC) : CW'(TIMEOUT);

  sr_hold_timer #(.CW(CW)) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .limit (limit),
    .tc    (tc)
  );

  // q_fb is used raw: it is only looked at in CHECK and at acceptance, where
  // the SR stage has had a full cycle to settle after S/R were released.
  always_comb begin
    nxt      = state;
    tgt_nxt  = tgt;
    clr      = 1'b0;
    en       = 1'b0;
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (accept) begin
          tgt_nxt = op_target(cmd.cmd_op, q_fb);
          nxt     = (cmd.cmd_op == OP_NOP) ? CHECK : DRIVE;
        end
      end
      DRIVE: begin
        if (tc) begin
          nxt = CHECK;
          clr = 1'b1;
        end else en = 1'b1;
      end
      CHECK: begin
        if (q_fb == tgt) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
          clr      = 1'b1;
        end else if (tc) begin
          nxt     = IDLE;
          err_nxt = 1'b1;
          clr     = 1'b1;
        end else en = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tgt     <= 1'b0;
      rdy_en  <= 1'b0;
      S       <= 1'b0;
      R       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state  <= nxt;
      tgt    <= tgt_nxt;
      rdy_en <= 1'b1;
      // S/R decoded from the next state so they are true flop outputs and
      // mutually exclusive by construction.
      S      <= (nxt == DRIVE) &&  tgt_nxt;
      R      <= (nxt == DRIVE) && !tgt_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      if (err_nxt && (err_cnt != 8'(ERR_CNT_MAX))) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_sr_cmd_sequencer.sv
module tb_sr_cmd_sequencer;
  import sr_cmd_pkg::*;

  localparam int HOLD = 1;
  localparam int TO   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       q_fb, S, R, busy, done, err;
  logic [7:0] err_cnt;
  logic       q_sr = 1'b0;
  logic       stuck;
  int         errors = 0;
  int         checks = 0;

  sr_cmd_sequencer_if cif ();

  sr_cmd_sequencer #(.HOLD_CYC(HOLD), .TIMEOUT(TO), .CW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cif.slave),
    .q_fb    (q_fb),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SR flip-flop downstream of the sequencer.
  always @(posedge clk) begin
    if (S && !R)      q_sr <= 1'b1;
    else if (R && !S) q_sr <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : q_sr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (cycle-index timeline) ----------------
  int   m_cyc = 0;
  logic m_idle = 1'b1;
  logic e_S = 0, e_R = 0, e_busy = 0, e_done = 0, e_err = 0, e_rdy = 0;
  int   e_cnt = 0;
  int   acc = 0, chk_start = 0;
  logic m_tgt = 0, m_nop = 0;

  always @(posedge clk) m_cyc++;

  always @(negedge clk) begin
    int   c;
    logic nd, ne;
    c = m_cyc;
    if (!rst_n) begin
      e_S = 0; e_R = 0; e_busy = 0; e_done = 0; e_err = 0; e_rdy = 0;
      e_cnt = 0; m_idle = 1'b1;
    end
    chk("S", S, e_S);
    chk("R", R, e_R);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("cmd_ready", cif.cmd_ready, e_rdy);
    chk("err_cnt", err_cnt, e_cnt);
    chk("S_and_R", S & R, 0);
    chk("done_and_err", done & err, 0);
    nd = 0; ne = 0;
    if (rst_n) begin
      if (m_idle) begin
        if (e_rdy && cif.cmd_valid) begin
          acc   = c;
          m_nop = (cif.cmd_op == OP_NOP);
          case (cif.cmd_op)
            OP_SET:  m_tgt = 1'b1;
            OP_RST:  m_tgt = 1'b0;
            OP_TGL:  m_tgt = ~q_fb;
            default: m_tgt = q_fb;
          endcase
          chk_start = c + 1 + (m_nop ? 0 : HOLD);
          m_idle    = 1'b0;
        end
      end else if (c >= chk_start) begin
        if (q_fb == m_tgt) begin
          nd = 1; m_idle = 1'b1;
        end else if (c - chk_start == TO - 1) begin
          ne = 1; m_idle = 1'b1;
          if (e_cnt < 255) e_cnt++;
        end
      end
      e_done = nd;
      e_err  = ne;
      e_busy = !m_idle;
      e_rdy  = m_idle;
      e_S    = !m_idle && !m_nop && (c + 1 <= acc + HOLD) &&  m_tgt;
      e_R    = !m_idle && !m_nop && (c + 1 <= acc + HOLD) && !m_tgt;
    end
  end

  // ---------------- stimulus ----------------
  // lat = edges from the accepting edge (counted as 1) until done/err is visible.
  task automatic run(input op_e op, output int lat, output logic gd, output logic ge);
    int k;
    cif.cmd_op    = op;
    cif.cmd_valid = 1'b1;
    k = 0;
    while (!cif.cmd_ready && k < 50) begin
      @(posedge clk); #2; k++;
    end
    if (k >= 50) begin
      errors++;
      $display("FAIL run_wait_ready: got timeout expected cmd_ready");
    end
    @(posedge clk); #2;
    cif.cmd_valid = 1'b0;
    lat = 1;
    while (!(done || err) && lat < 50) begin
      @(posedge clk); #2; lat++;
    end
    gd = done;
    ge = err;
  endtask

  initial begin
    int   lat, k, na, nd;
    logic gd, ge, pr;
    rst_n = 1'b0; stuck = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_op = OP_NOP;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready", cif.cmd_ready, 0);
    chk("reset_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_first_edge", cif.cmd_ready, 1);

    run(OP_SET, lat, gd, ge);
    chk("set_lat", lat, 3); chk("set_done", gd, 1); chk("set_q", q_sr, 1); chk("set_cnt", err_cnt, 0);

    run(OP_TGL, lat, gd, ge);
    chk("tgl1_lat", lat, 3); chk("tgl1_done", gd, 1); chk("tgl1_q", q_sr, 0);
    run(OP_TGL, lat, gd, ge);
    chk("tgl2_lat", lat, 3); chk("tgl2_done", gd, 1); chk("tgl2_q", q_sr, 1);

    run(OP_NOP, lat, gd, ge);
    chk("nop_lat", lat, 2); chk("nop_done", gd, 1); chk("nop_q", q_sr, 1);

    stuck = 1'b1;
    run(OP_SET, lat, gd, ge);
    chk("to_lat", lat, 6); chk("to_err", ge, 1); chk("to_done", gd, 0); chk("to_cnt", err_cnt, 1);
    for (int i = 0; i < 259; i++) run(OP_SET, lat, gd, ge);
    chk("to_sat_cnt", err_cnt, 255);
    stuck = 1'b0;

    run(OP_RST, lat, gd, ge);
    chk("rst_cmd_lat", lat, 3); chk("rst_cmd_q", q_sr, 0);

    // Async reset in the middle of DRIVE.
    cif.cmd_op = OP_SET; cif.cmd_valid = 1'b1;
    k = 0;
    while (!cif.cmd_ready && k < 50) begin
      @(posedge clk); #2; k++;
    end
    @(posedge clk); #2;
    cif.cmd_valid = 1'b0;
    chk("drive_S", S, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_S", S, 0); chk("abort_R", R, 0); chk("abort_busy", busy, 0);
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("abort_ready", cif.cmd_ready, 1);
    chk("abort_cnt", err_cnt, 0);
    chk("abort_q", q_sr, 0);

    // Continuous valid, alternating SET/RESET.
    na = 0; nd = 0;
    cif.cmd_op = OP_SET; cif.cmd_valid = 1'b1;
    pr = cif.cmd_ready;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (pr) begin
        na++;
        cif.cmd_op = (cif.cmd_op == OP_SET) ? OP_RST : OP_SET;
      end
      if (done) nd++;
      pr = cif.cmd_ready;
    end
    cif.cmd_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #2;
      if (done) nd++;
    end
    chk("b2b_accepts", na, 20);
    chk("b2b_dones", nd, na);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
